decision_issuer: RTL and testbench
==================================

Name: decision_issuer

Overview:
- Initiator-side driver for the `decision` block. It buffers operand triples (x1, x2, x3) arriving on a valid/ready port and issues them one at a time as a start pulse plus held operands.
- It waits for the block's `y_o`/`y_valid_o`, then returns each result on a valid/ready result port.
- A timeout guards against a missing `y_valid`.
- Sits between the upstream operand source and `decision`.

Parameters:
- WIDTH, 8, operand/result width (matches `decision`).
- DEPTH, 4, operand FIFO entries; power of 2, ≥2.
- TIMEOUT, 64, max cycles in WAIT before aborting; ≥2.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  operand triple valid.
- in_ready_o  out  1  FIFO can accept; equals not-full.
- in_x1_i  in  WIDTH  operand 1.
- in_x2_i  in  WIDTH  operand 2.
- in_x3_i  in  WIDTH  operand 3.
- start_o  out  1  one-cycle start pulse to `decision` `start_i`.
- x1_o  out  WIDTH  held operand to `decision` x1.
- x2_o  out  WIDTH  held operand to `decision` x2.
- x3_o  out  WIDTH  held operand to `decision` x3.
- y_i  in  WIDTH  from `decision` `y_o`.
- y_valid_i  in  1  from `decision` `y_valid_o`.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  result consumer ready.
- res_y_o  out  WIDTH  captured result; 0 on timeout.
- res_timeout_o  out  1  result is a timeout abort; qualified by `res_valid_o`.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, async):
  - FIFO emptied; pointers and count cleared; state IDLE.
  - Output reset values: start_o=0, x1_o/x2_o/x3_o=0, res_valid_o=0, res_y_o=0, res_timeout_o=0, busy_o=0, in_ready_o=1 once out of reset.
  - Reset mid-transaction discards the in-flight triple and all queued triples; no result is produced for them.
- FIFO:
  - Push when in_valid_i && in_ready_o.
  - in_ready_o = (count != DEPTH), registered-count based.
  - No bypass: a full FIFO refuses a push even when a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
  - count width is clog2(DEPTH)+1.
  - Push and pop in the same cycle leave count unchanged.
- State machine:
  - IDLE: if FIFO non-empty, pop head into x1_o/x2_o/x3_o and go to ISSUE. A triple pushed at edge N is popped at edge N+1 at the earliest.
  - ISSUE (1 cycle): start_o=1; timeout counter cleared; go to WAIT.
    - If y_valid_i=1 in this cycle, treat it as in WAIT.
  - WAIT: start_o=0; counter increments each cycle.
    - If y_valid_i=1: res_y_o<=y_i, res_timeout_o<=0, res_valid_o<=1, go to RESP.
    - Else if counter==TIMEOUT-1: res_y_o<=0, res_timeout_o<=1, res_valid_o<=1, go to RESP.
    - If y_valid_i arrives on the timeout cycle, the valid result wins.
  - RESP: hold res_* stable until res_ready_i=1. On that edge: res_valid_o<=0, go to IDLE.
- Operand hold: x1_o/x2_o/x3_o hold their value from pop until the next pop, including through RESP and IDLE.
- Stray pulses: y_valid_i in IDLE or RESP is ignored and has no side effects.
- Throughput: one transaction per 4 + decision-latency cycles minimum. Transactions are strictly in order and never overlap.
- FIFO during activity: accepts pushes in every state while not full.

Test Plan:
- Basic: reset low 2 cycles, release. Push (8'h12, 8'h34, 8'h56).
  → start_o high exactly 1 cycle, 2 cycles after push; x1_o/x2_o/x3_o = 12/34/56.
  → Model returns y_i=8'h34 with y_valid 3 cycles later → res_valid_o=1, res_y_o=8'h34, res_timeout_o=0.
- Backpressure: hold res_ready_i=0 for 10 cycles with a result pending.
  → res_valid_o and res_y_o stable; no new start_o.
  → After res_ready_i=1: next queued triple issues 2 cycles later.
- FIFO full: with the model never responding, push 6 triples back-to-back.
  → Sequence: 1 popped into ISSUE, 4 buffered, then in_ready_o=0; the 6th is held off until a pop.
  → Results return in push order.
- Timeout: model never asserts y_valid.
  → res_valid_o rises TIMEOUT=64 cycles after the start_o cycle, with res_timeout_o=1 and res_y_o=0.
  → A y_valid on the exact timeout cycle gives res_timeout_o=0 instead.
- Stray y_valid: pulse y_valid_i=1, y_i=8'hFF while IDLE and while in RESP.
  → No change to res_y_o; no extra result.
- Reset mid-WAIT: with 2 queued triples, assert reset.
  → All outputs reach reset values immediately (async); busy_o=0.
  → After release, no start_o until a new push.

Source files
------------

// File: rtl/decision_issuer.sv
// Initiator-side driver for the decision block: buffers operand triples, issues them one
// at a time with a start pulse, waits for y_valid (or a timeout) and returns each result.
module decision_issuer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_x1_i,
    input  logic [WIDTH-1:0] in_x2_i,
    input  logic [WIDTH-1:0] in_x3_i,
    output logic             start_o,
    output logic [WIDTH-1:0] x1_o,
    output logic [WIDTH-1:0] x2_o,
    output logic [WIDTH-1:0] x3_o,
    input  logic [WIDTH-1:0] y_i,
    input  logic             y_valid_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_y_o,
    output logic             res_timeout_o,
    output logic             busy_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state, next_state;
    logic [3*WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [TO_W-1:0]      tcnt;
    logic                 push, pop;
    logic                 res_load, res_to, res_clear;

    assign in_ready_o = (count != CNT_W'(DEPTH));
    assign push       = in_valid_i && in_ready_o;
    assign busy_o     = (state != IDLE);

    // Operand storage carries no reset; only pointers and count define occupancy.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= {in_x1_i, in_x2_i, in_x3_i};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        start_o    = 1'b0;
        res_load   = 1'b0;
        res_to     = 1'b0;
        res_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                start_o = 1'b1;
                // A same-cycle response is accepted as if already waiting.
                if (y_valid_i) begin
                    res_load   = 1'b1;
                    next_state = RESP;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (y_valid_i) begin
                    res_load   = 1'b1;
                    next_state = RESP;
                end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                    res_load   = 1'b1;
                    res_to     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (res_ready_i) begin
                    res_clear  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x1_o          <= '0;
            x2_o          <= '0;
            x3_o          <= '0;
            tcnt          <= '0;
            res_valid_o   <= 1'b0;
            res_y_o       <= '0;
            res_timeout_o <= 1'b0;
        end else begin
            if (pop)
                {x1_o, x2_o, x3_o} <= mem[rd_ptr];
            if (state == ISSUE)
                tcnt <= '0;
            else if (state == WAIT)
                tcnt <= tcnt + TO_W'(1);
            if (res_load) begin
                res_valid_o   <= 1'b1;
                res_y_o       <= res_to ? '0 : y_i;
                res_timeout_o <= res_to;
            end else if (res_clear) begin
                res_valid_o   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decision_issuer.sv
// Directed bench for decision_issuer: the decision block is played by hand-driven
// y_i/y_valid_i, and every expected value is written out in the stimulus.
module tb_decision_issuer;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_x1_i, in_x2_i, in_x3_i;
    logic             start_o;
    logic [WIDTH-1:0] x1_o, x2_o, x3_o;
    logic [WIDTH-1:0] y_i;
    logic             y_valid_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [WIDTH-1:0] res_y_o;
    logic             res_timeout_o;
    logic             busy_o;

    int total = 0;
    int bad   = 0;

    decision_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_x1_i(in_x1_i), .in_x2_i(in_x2_i), .in_x3_i(in_x3_i),
        .start_o(start_o), .x1_o(x1_o), .x2_o(x2_o), .x3_o(x3_o),
        .y_i(y_i), .y_valid_i(y_valid_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_y_o(res_y_o), .res_timeout_o(res_timeout_o), .busy_o(busy_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int k;
        in_valid_i = 1'b1;
        in_x1_i = a; in_x2_i = b; in_x3_i = c;
        k = 0;
        while (!in_ready_o && k < 200) begin
            tick();
            k++;
        end
        if (k == 200) chk("push_ready_bound", 32'(in_ready_o), 32'd1);
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic wait_start(input string tag, input logic [7:0] exp_x1);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (start_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_start"}, 32'(ok), 32'd1);
        chk({tag, "_x1"}, 32'(x1_o), 32'(exp_x1));
    endtask

    task automatic finish_txn(input string tag, input logic [7:0] y);
        y_valid_i = 1'b1;
        y_i = y;
        tick();
        y_valid_i = 1'b0;
        chk({tag, "_rvalid"}, 32'(res_valid_o), 32'd1);
        chk({tag, "_ry"}, 32'(res_y_o), 32'(y));
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
    endtask

    initial begin
        int  n;
        logic seen;
        reset = 1'b0; in_valid_i = 1'b0; y_valid_i = 1'b0; res_ready_i = 1'b0;
        in_x1_i = '0; in_x2_i = '0; in_x3_i = '0; y_i = '0;
        repeat (2) tick();
        chk("rst_start", 32'(start_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rvalid", 32'(res_valid_o), 32'd0);
        chk("rst_x1", 32'(x1_o), 32'd0);
        chk("rst_ry", 32'(res_y_o), 32'd0);
        chk("rst_rto", 32'(res_timeout_o), 32'd0);
        reset = 1'b1;
        tick();
        chk("rst_ready", 32'(in_ready_o), 32'd1);

        // Basic transaction; a second triple is queued while the first waits.
        push(8'h12, 8'h34, 8'h56);
        chk("basic_nostart_yet", 32'(start_o), 32'd0);
        tick();
        chk("basic_start", 32'(start_o), 32'd1);
        chk("basic_x1", 32'(x1_o), 32'h12);
        chk("basic_x2", 32'(x2_o), 32'h34);
        chk("basic_x3", 32'(x3_o), 32'h56);
        chk("basic_busy", 32'(busy_o), 32'd1);
        push(8'hAA, 8'hBB, 8'hCC);
        chk("basic_start_1cyc", 32'(start_o), 32'd0);
        repeat (2) tick();
        y_valid_i = 1'b1; y_i = 8'h34;
        tick();
        y_valid_i = 1'b0;
        chk("basic_rvalid", 32'(res_valid_o), 32'd1);
        chk("basic_ry", 32'(res_y_o), 32'h34);
        chk("basic_rto", 32'(res_timeout_o), 32'd0);

        // Backpressure with a stray y_valid pulse while in RESP.
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin y_valid_i = 1'b1; y_i = 8'hFF; end
            tick();
            y_valid_i = 1'b0;
            chk("bp_rvalid", 32'(res_valid_o), 32'd1);
            chk("bp_ry", 32'(res_y_o), 32'h34);
            chk("bp_nostart", 32'(start_o), 32'd0);
        end
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk("bp_rvalid_drop", 32'(res_valid_o), 32'd0);
        chk("bp_nostart_idle", 32'(start_o), 32'd0);
        tick();
        chk("bp_next_start", 32'(start_o), 32'd1);
        chk("bp_next_x1", 32'(x1_o), 32'hAA);

        // Timeout: ISSUE cycle plus TIMEOUT cycles in WAIT, result visible on the next edge.
        n = 0;
        do begin
            tick();
            n++;
        end while (!res_valid_o && n < 200);
        chk("to_latency", 32'(n), 32'(TIMEOUT + 1));
        chk("to_flag", 32'(res_timeout_o), 32'd1);
        chk("to_ry", 32'(res_y_o), 32'd0);
        chk("to_x1_held", 32'(x1_o), 32'hAA);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk("to_rvalid_drop", 32'(res_valid_o), 32'd0);
        chk("to_idle", 32'(busy_o), 32'd0);

        // Stray y_valid while IDLE.
        y_valid_i = 1'b1; y_i = 8'hFF;
        tick();
        y_valid_i = 1'b0;
        tick();
        chk("stray_rvalid", 32'(res_valid_o), 32'd0);
        chk("stray_ry", 32'(res_y_o), 32'd0);
        chk("stray_busy", 32'(busy_o), 32'd0);

        // y_valid on the exact timeout cycle wins over the timeout.
        push(8'h01, 8'h02, 8'h03);
        wait_start("race", 8'h01);
        repeat (TIMEOUT) tick();
        chk("race_not_yet", 32'(res_valid_o), 32'd0);
        y_valid_i = 1'b1; y_i = 8'h77;
        tick();
        y_valid_i = 1'b0;
        chk("race_rvalid", 32'(res_valid_o), 32'd1);
        chk("race_rto", 32'(res_timeout_o), 32'd0);
        chk("race_ry", 32'(res_y_o), 32'h77);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;

        // Response arriving in the ISSUE cycle itself.
        push(8'h05, 8'h06, 8'h07);
        wait_start("issue_rsp", 8'h05);
        finish_txn("issue_rsp", 8'h5A);

        // FIFO full: item 0 goes to ISSUE, items 1..4 fill the FIFO, item 5 is held off.
        for (int i = 0; i < 5; i++) begin
            chk("full_ready_pre", 32'(in_ready_o), 32'd1);
            in_valid_i = 1'b1;
            in_x1_i = 8'(8'h20 + i); in_x2_i = 8'h00; in_x3_i = 8'h00;
            tick();
        end
        in_x1_i = 8'h25;
        chk("full_ready_low", 32'(in_ready_o), 32'd0);
        chk("full_x1_item0", 32'(x1_o), 32'h20);
        repeat (3) begin
            tick();
            chk("full_held_off", 32'(in_ready_o), 32'd0);
        end
        finish_txn("full_item0", 8'h21);
        chk("full_ready_resp", 32'(in_ready_o), 32'd0);
        tick();
        chk("full_item1_start", 32'(start_o), 32'd1);
        chk("full_item1_x1", 32'(x1_o), 32'h21);
        chk("full_ready_after_pop", 32'(in_ready_o), 32'd1);
        tick();
        in_valid_i = 1'b0;
        chk("full_ready_refull", 32'(in_ready_o), 32'd0);
        finish_txn("full_item1", 8'h22);
        for (int i = 2; i < 6; i++) begin
            wait_start("full_order", 8'(8'h20 + i));
            finish_txn("full_order", 8'(8'h21 + i));
        end
        chk("full_drained", 32'(busy_o), 32'd0);

        // Reset mid-WAIT with two triples queued.
        push(8'hA0, 8'h00, 8'h00);
        wait_start("rmid", 8'hA0);
        push(8'hB0, 8'h00, 8'h00);
        push(8'hC0, 8'h00, 8'h00);
        #2 reset = 1'b0;
        #1;
        chk("rmid_start", 32'(start_o), 32'd0);
        chk("rmid_busy", 32'(busy_o), 32'd0);
        chk("rmid_x1", 32'(x1_o), 32'd0);
        chk("rmid_rvalid", 32'(res_valid_o), 32'd0);
        chk("rmid_ready", 32'(in_ready_o), 32'd1);
        tick();
        reset = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (start_o || busy_o || res_valid_o) seen = 1'b1;
        end
        chk("rmid_quiet", 32'(seen), 32'd0);
        push(8'hD0, 8'h00, 8'h00);
        wait_start("rmid_new", 8'hD0);
        finish_txn("rmid_new", 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
